// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int unsigned STAT_W = 16;

    // Index width for n items; never below one bit so ports stay legal.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: first set req bit after last_owner, wrapping.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    int unsigned idx;

    // Scan farthest-first so the nearest candidate after last_owner wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx = (32'(last_owner) + k) % NUM_REQ;
            if (req[ID_W'(idx)]) begin
                winner = ID_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of the async FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-requester saturating grant counters (stat_cnt).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ      = 4,
    parameter int unsigned  WIDTH        = 8,
    parameter int unsigned  MAX_BURST    = 4,
    parameter int unsigned  IDLE_TIMEOUT = 8,
    localparam int unsigned ID_W         = id_w(NUM_REQ)
) (
    input  logic                     w_clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic                     full,
    output logic                     w_en,
    output logic [WIDTH-1:0]         data_in,
    output logic                     busy,
    output logic [ID_W-1:0]          owner_id
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_cnt
`endif
);

    localparam int unsigned BEAT_W = id_w(MAX_BURST);
    localparam int unsigned IDLE_W = id_w(IDLE_TIMEOUT);

    state_t              state;
    logic [ID_W-1:0]     owner;
    logic [ID_W-1:0]     last_owner;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    logic [ID_W-1:0]     pick_id;
    logic                pick_valid;
    logic [WIDTH-1:0]    lane [NUM_REQ];
    logic                owner_req;
    logic                owner_last;
    logic [WIDTH-1:0]    owner_data;
    logic                in_burst;
    logic                beat;

    rr_picker #(
        .NUM_REQ    (NUM_REQ)
    ) u_picker (
        .req        (req),
        .last_owner (last_owner),
        .winner     (pick_id),
        .valid      (pick_valid)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Owner view of the request bus; everything is gated by rst so a beat
    // presented during reset is never acknowledged.
    always_comb begin
        owner_req  = req[owner];
        owner_last = req_last[owner];
        owner_data = lane[owner];
        in_burst   = (state == BURST) && rst;
        beat       = in_burst && owner_req && !full;
    end

    always_comb begin
        gnt        = '0;
        gnt[owner] = beat;
        w_en       = beat;
        data_in    = beat ? owner_data : '0;
        busy       = in_burst;
        owner_id   = in_burst ? owner : '0;
    end

    always_ff @(posedge w_clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= ID_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
            idle_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_id;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (beat) begin
                        idle_cnt <= '0;
                        if (owner_last || (beat_cnt == BEAT_W'(MAX_BURST - 1))) begin
                            state      <= IDLE;
                            last_owner <= owner;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end else if (owner_req) begin
                        // Backpressure stall: owner is still active.
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        state      <= IDLE;
                        last_owner <= owner;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        always_ff @(posedge w_clk) begin
            if (!rst) begin
                stat_q[g] <= '0;
            end else if (gnt[g] && (stat_q[g] != {STAT_W{1'b1}})) begin
                stat_q[g] <= stat_q[g] + STAT_W'(1);
            end
        end
        assign stat_cnt[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule
